// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Glyphs are active-low with bit6=g down to bit0=a.
package display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/display_scan_driver_if.sv
// Datapath-side load bus plus board-side pin bundle of the scan driver.
interface display_scan_driver_if #(parameter int N_DIGITS = 4);
  logic [4*N_DIGITS-1:0] valor;
  logic                  cargar;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  lz_en;
  logic                  blink_en;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an_n;

  modport master (output valor, cargar, dp_in, blank_in, lz_en, blink_en,
                  input  seg_n, dp_n, an_n);
  modport slave  (input  valor, cargar, dp_in, blank_in, lz_en, blink_en,
                  output seg_n, dp_n, an_n);
endinterface

// File: rtl/hex_7seg.sv
// Combinational nibble to active-low 7-segment glyph.
module hex_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed hex display driver: shadow register, digit scan, blanking,
// leading-zero suppression and blink, all outputs registered.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 250
) (
  input logic clk,
  input logic rst_n,
  display_scan_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [N_DIGITS-1:0][3:0] sh_val;
  logic [N_DIGITS-1:0]      sh_dp, sh_blank;
  logic [CW-1:0]            scan_cnt;
  logic [IW-1:0]            idx, idx_n;
  logic [BW-1:0]            blink_cnt;
  logic                     phase;
  logic                     tick, lz_zero, blank;
  logic [6:0]               glyph, seg_q;
  logic                     dp_q;
  logic [N_DIGITS-1:0]      an_q;

  assign tick  = (scan_cnt == CNT_LAST);
  assign idx_n = !tick ? idx : (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (bus.cargar) begin
        sh_val   <= bus.valor;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_in;
      end
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      idx      <= idx_n;
      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_zero = 1'b1;
    for (int k = 0; k < N_DIGITS; k++)
      if (k >= int'(idx_n) && sh_val[k] != 4'h0) lz_zero = 1'b0;
    blank = sh_blank[idx_n] | (bus.lz_en && idx_n != '0 && lz_zero);
  end

  hex_7seg u_hex (.nib(sh_val[idx_n]), .seg(glyph));

  // Segments are fed from the upcoming index so they settle while the
  // anodes are dark for the one dead cycle after each digit tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= blank ? SEG_BLANK : glyph;
      dp_q  <= blank | ~sh_dp[idx_n];
      an_q  <= (tick || (bus.blink_en && phase)) ? '1 : ~(N_DIGITS'(1) << idx_n);
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;
  assign bus.an_n  = an_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench: stimulus queues one record per expected lit-digit run,
// the monitor checks each run when its anode goes dark.
module tb_display_scan_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  display_scan_driver_if #(.N_DIGITS(4)) b ();

  display_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;   // -1: gap not checked
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLK = 7'b1111111;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  task automatic push(int d, logic [6:0] s, logic dp, int len, int gap);
    exp_t e;
    e.an = ~(4'b0001 << d);
    e.seg = s;
    e.dp = dp;
    e.len = len;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Returns at the falling edge right after the first post-reset rising edge,
  // on which the new value was loaded.
  task automatic rst_load(logic [15:0] v, logic [3:0] dp, logic [3:0] bl);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b.cargar = 1'b1;
    b.valor = v;
    b.dp_in = dp;
    b.blank_in = bl;
    @(negedge clk);
    b.cargar = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, q.size(), 0);
    q.delete();
  endtask

  // Monitor: a lit run ends when an_n returns to all ones.
  initial begin
    logic [3:0] p_an;
    logic [6:0] p_seg;
    logic       p_dp;
    int lit, dead, gap;
    exp_t e;
    p_an = 4'hF; p_seg = BLK; p_dp = 1'b1;
    lit = 0; dead = 0; gap = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (b.an_n === 4'hF) begin
        if (p_an !== 4'hF) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("an", p_an, e.an);
            chk("seg", p_seg, e.seg);
            chk("dp", p_dp, e.dp);
            chk("len", lit, e.len);
            if (e.gap >= 0) chk("gap", gap, e.gap);
          end
          dead = 0;
        end
        dead++;
      end else begin
        if (p_an === 4'hF) begin
          gap = dead;
          lit = 0;
        end
        lit++;
      end
      p_an = b.an_n; p_seg = b.seg_n; p_dp = b.dp_n;
    end
  end

  initial begin
    rst_n = 1'b0;
    b.valor = '0; b.cargar = 1'b0; b.dp_in = '0; b.blank_in = '0;
    b.lz_en = 1'b0; b.blink_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", b.seg_n, 7'h7F);
    chk("rst_an", b.an_n, 4'hF);
    chk("rst_dp", b.dp_n, 1'b1);

    // Scan order and wrap back to digit 0
    rst_load(16'h1A3F, 4'b0000, 4'b0000);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 1, 3, 1);
    push(2, 7'b0001000, 1, 3, 1);
    push(3, 7'b1111001, 1, 3, 1);
    push(0, 7'b0001110, 1, 3, 1);
    drain("scan");

    // Full glyph table, four nibbles per load
    for (int g = 0; g < 4; g++) begin
      logic [15:0] v;
      v = {4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)};
      rst_load(v, 4'b0000, 4'b0000);
      for (int d = 0; d < 4; d++) push(d, GL[4*g+d], 1, 3, d == 0 ? -1 : 1);
      drain("sweep");
    end

    // Decimal point on digit 1
    rst_load(16'h1A3F, 4'b0010, 4'b0000);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 0, 3, 1);
    push(2, 7'b0001000, 1, 3, 1);
    drain("dp");

    // Leading-zero suppression
    b.lz_en = 1'b1;
    rst_load(16'h0000, 4'b0000, 4'b0000);
    push(0, 7'b1000000, 1, 3, -1);
    push(1, BLK, 1, 3, 1);
    push(2, BLK, 1, 3, 1);
    push(3, BLK, 1, 3, 1);
    drain("lz0");
    rst_load(16'h00B0, 4'b1000, 4'b0000);
    push(0, 7'b1000000, 1, 3, -1);
    push(1, 7'b0000011, 1, 3, 1);
    push(2, BLK, 1, 3, 1);
    push(3, BLK, 1, 3, 1);
    drain("lzB0");
    rst_load(16'h0102, 4'b0000, 4'b0000);
    push(0, 7'b0100100, 1, 3, -1);
    push(1, 7'b1000000, 1, 3, 1);
    push(2, 7'b1111001, 1, 3, 1);
    push(3, BLK, 1, 3, 1);
    drain("lz0102");
    b.lz_en = 1'b0;

    // Forced blank on digit 2 overrides its decimal point
    rst_load(16'h1A3F, 4'b0100, 4'b0100);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 1, 3, 1);
    push(2, BLK, 1, 3, 1);
    push(3, 7'b1111001, 1, 3, 1);
    drain("blank");

    // Blink: two digit periods visible, two dark (plus the dead cycle)
    b.blink_en = 1'b1;
    rst_load(16'h1A3F, 4'b0000, 4'b0000);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 1, 3, 1);
    push(0, 7'b0001110, 1, 3, 9);
    push(1, 7'b0110000, 1, 3, 1);
    push(0, 7'b0001110, 1, 3, 9);
    drain("blink");
    b.blink_en = 1'b0;

    // Load coincident with the digit 1 -> 2 tick
    rst_load(16'h1A3F, 4'b0000, 4'b0000);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 1, 3, 1);
    push(2, 7'b0011001, 1, 3, 1);
    push(3, 7'b0000000, 1, 3, 1);
    repeat (6) @(negedge clk);
    b.cargar = 1'b1;
    b.valor = 16'h84E2;
    @(negedge clk);
    b.cargar = 1'b0;
    drain("tickload");

    // Reset one cycle into digit 1: scan restarts at digit 0, shadow cleared
    rst_load(16'h1A3F, 4'b0000, 4'b0000);
    push(0, 7'b0001110, 1, 3, -1);
    push(1, 7'b0110000, 1, 1, 1);
    push(0, 7'b1000000, 1, 3, -1);
    push(1, 7'b1000000, 1, 3, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Parametrised multiplexed hex display driver for the board's common-anode 7-segment bank. Holds an N-digit hex value in a shadow register loaded by a strobe, time-multiplexes the digits at a programmable refresh rate, decodes each nibble to correct 0–F glyphs, and supports per-digit blanking, decimal points, leading-zero suppression and whole-display blink. Sits between the datapath and the board pins; replaces per-digit static decoders.

## Interface
- `N_DIGITS`, 4: digits driven; legal 1..8.
- `REFRESH_DIV`, 50000: clock cycles each digit is selected; legal ≥ 2.
- `BLINK_DIV`, 250: digit ticks per blink half-period; legal ≥ 1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  **synchronous, active-low** reset, sampled on the rising edge of `clk`.
- `valor`  in  4·N_DIGITS  hex value; nibble k drives digit k (digit 0 = rightmost).
- `cargar`  in  1  load strobe; `valor`, `dp_in`, `blank_in` captured when high.
- `dp_in`  in  N_DIGITS  decimal point per digit, active-high.
- `blank_in`  in  N_DIGITS  per-digit force-blank, active-high.
- `lz_en`  in  1  leading-zero suppression enable (live, not latched).
- `blink_en`  in  1  blink enable (live).
- `seg_n`  out  7  segments, active-low, bit0=a … bit6=g.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  N_DIGITS  digit anodes, active-low, at most one low.

## Operation
- Reset: `seg_n`=7'b1111111, `dp_n`=1, `an_n`=all ones; shadow value/dp/blank=0; scan counter, digit index, blink counter and blink phase=0 (phase 0 = visible).
- Load: on any edge with `cargar`=1, shadow ← {`valor`,`dp_in`,`blank_in`}. No ack; one load per cycle; holding `cargar` high reloads every cycle.
- Scan: counter runs 0..REFRESH_DIV−1; at terminal count (the "digit tick") it wraps to 0 and index advances, wrapping N_DIGITS−1 → 0.
- Blink: blink counter increments on each digit tick, wraps at BLINK_DIV−1 and toggles phase. Counter runs regardless of `blink_en`; when `blink_en`=1 and phase=1 all anodes are off.
- Glyphs (active-low, g..a): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Digit k blank if: shadow blank bit k, or `lz_en`=1 and k≠0 and nibbles k..N_DIGITS−1 all zero. Digit 0 never suppressed by `lz_en`. Blank digit: `seg_n`=7'b1111111, `dp_n`=1, anode still driven (uniform brightness).
- Decimal point follows shadow dp bit even when the nibble is a suppressed zero? No: blanked digits force `dp_n`=1.

## Timing
- All outputs registered; one-cycle latency from {index, shadow, `lz_en`, `blink_en`} to pins.
- Ghost blanking: on the cycle after a digit tick, `an_n` is all ones; new digit's anode goes low the following cycle. `seg_n` updates during that dead cycle.
- `cargar` at edge t → shadow at t → pins reflect new content at edge t+1 for the currently selected digit.
- `cargar` coincident with digit tick: shadow and index update on the same edge; the dead cycle masks the transition, new digit shows new content.
- `rst_n` low mid-scan: all state to reset values on that edge; scan restarts at digit 0 with full REFRESH_DIV period.
- N_DIGITS=1: index constant 0, dead cycle still inserted each tick.

## Structure
- Package `display_pkg`: 7-bit glyph constants for 0–F, `SEG_BLANK`=7'b1111111, segment bit-order localparams.
- Sub-module `hex_7seg` (combinational nibble → active-low glyph from package), instantiated once on the muxed nibble.
- Counter widths via $clog2 of REFRESH_DIV, BLINK_DIV, N_DIGITS.

## Test plan
- Reset hold then release: `seg_n`=7F, `an_n`=F, `dp_n`=1 during reset; first anode (`an_n`=4'b1110) low REFRESH_DIV+… per spec cycles after release, with one dead cycle seen.
- REFRESH_DIV=4, load 16'h1A3F: digit 0..3 show 0001110, 0110000, 0001000, 1111001 in order; each anode low 3 cycles, all-off 1 cycle.
- Sweep nibble 0–F on digit 0: `seg_n` matches glyph table exactly.
- `lz_en`=1, load 16'h0000 → only digit 0 shows 1000000; load 16'h00B0 → digits 3,2 blank, digit 1 shows 0000011; `dp_in`=4'b1000 on digit 3 → `dp_n` stays 1.
- `blink_en`=1, BLINK_DIV=2: anodes all off for exactly 2 digit ticks, on for 2, repeating; `blank_in`=4'b0100 blanks digit 2 only.
- `cargar` on the digit-tick edge and `rst_n` asserted mid-period: new value on next digit, reset restarts scan at digit 0.
